fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and drives a synchronous instruction ROM with 1-cycle read latency. It presents one 9-bit instruction per cycle to the decoder with a valid flag, and handles stall, taken-branch redirect/squash, and halt detection. Execute supplies branch outcomes; the top level supplies start and observes done.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM
// and hands one instruction per cycle to the decoder with stall, redirect and halt handling.
module fetch_unit #(
  parameter int unsigned     PC_W       = 10,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [8:0]      HALT_INSTR = 9'h1FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rdata,
  output logic [8:0]      instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  output logic            busy,
  output logic            done
);

  localparam int unsigned INSTR_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_pc_q, req_pc_d;
  logic                req_valid_q, req_valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                halt_hit;

  // Only a live (non-squashed) ROM slot may terminate the program.
  assign halt_hit = req_valid_q && (imem_rdata == HALT_INSTR);

  // While stalled the pending address is re-read so ROM data stays aligned with req_pc.
  assign imem_addr = ((state_q == S_FETCH) && stall) ? req_pc_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = RESET_PC;
          req_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          // Squash both wrong-path slots: the ROM read and the output register.
          pc_d          = branch_target;
          req_valid_d   = 1'b0;
          instr_valid_d = 1'b0;
        end else if (!stall) begin
          if (halt_hit) begin
            state_d       = S_HALT;
            done_d        = 1'b1;
            instr_valid_d = 1'b0;
            req_valid_d   = 1'b0;
          end else begin
            req_pc_d      = pc_q;
            req_valid_d   = 1'b1;
            pc_d          = pc_q + PC_W'(1);
            instr_d       = imem_rdata;
            instr_pc_d    = req_pc_q;
            instr_valid_d = req_valid_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      req_valid_q   <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
